// File: rtl/id_pkg.sv
// Shared constants and types for the decode-stage scoreboard.
package id_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 32;

    localparam int FWD_EX  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    typedef struct packed {
        logic              we;
        logic [DEF_AW-1:0] waddr;
        logic [DEF_DW-1:0] wdata;
    } fwd_src_t;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand forwarding: youngest matching source wins, register 0 reads as zero.
module fwd_mux #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int N_FWD = 3
) (
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       rf_rdata,
    input  logic [N_FWD-1:0]    fwd_we,
    input  logic [N_FWD*AW-1:0] fwd_waddr,
    input  logic [N_FWD*DW-1:0] fwd_wdata,
    output logic [DW-1:0]       data
);

    // Walk oldest to youngest so the youngest hit is the last assignment.
    always_comb begin
        data = rf_rdata;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == addr)) begin
                data = fwd_wdata[i*DW +: DW];
            end
        end
        if (addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage hazard unit: per-register load latency tracking, HI/LO busy counter,
// and operand forwarding for rs/rt.
module id_scoreboard
    import id_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int N_FWD    = 3,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                stall_in,
    input  logic                id_valid,
    input  logic [AW-1:0]       id_rs,
    input  logic [AW-1:0]       id_rt,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic                id_rf_we,
    input  logic [AW-1:0]       id_waddr,
    input  logic                id_is_load,
    input  logic                id_is_md,
    input  logic                id_reads_hilo,
    input  logic [DW-1:0]       rf_rdata1,
    input  logic [DW-1:0]       rf_rdata2,
    input  logic [N_FWD-1:0]    fwd_we,
    input  logic [N_FWD*AW-1:0] fwd_waddr,
    input  logic [N_FWD*DW-1:0] fwd_wdata,
    output logic [DW-1:0]       rs_data,
    output logic [DW-1:0]       rt_data,
    output logic                stallreq,
    output logic                issue,
    output logic                hilo_busy
);

    localparam int NREG = 2 ** AW;
    localparam int PW   = $clog2(LOAD_LAT + 2);
    localparam int HW   = (MD_LAT > 0) ? $clog2(MD_LAT + 1) : 1;

    localparam logic [PW-1:0] LOAD_SET = PW'(LOAD_LAT + 1);
    localparam logic [HW-1:0] MD_SET   = HW'(MD_LAT);

    logic [PW-1:0] pend_cnt [NREG];
    logic [HW-1:0] hilo_cnt;

    logic rs_haz;
    logic rt_haz;
    logic hilo_haz;

    fwd_mux #(
        .AW    (AW),
        .DW    (DW),
        .N_FWD (N_FWD)
    ) u_fwd_rs (
        .addr      (id_rs),
        .rf_rdata  (rf_rdata1),
        .fwd_we    (fwd_we),
        .fwd_waddr (fwd_waddr),
        .fwd_wdata (fwd_wdata),
        .data      (rs_data)
    );

    fwd_mux #(
        .AW    (AW),
        .DW    (DW),
        .N_FWD (N_FWD)
    ) u_fwd_rt (
        .addr      (id_rt),
        .rf_rdata  (rf_rdata2),
        .fwd_we    (fwd_we),
        .fwd_waddr (fwd_waddr),
        .fwd_wdata (fwd_wdata),
        .data      (rt_data)
    );

    // A count of 1 means the load data already sits on a forwarding source.
    always_comb begin
        rs_haz   = id_rs_used && (id_rs != '0) && (pend_cnt[id_rs] > PW'(1));
        rt_haz   = id_rt_used && (id_rt != '0) && (pend_cnt[id_rt] > PW'(1));
        hilo_haz = (id_reads_hilo || id_is_md) && hilo_busy;
        stallreq = id_valid && (rs_haz || rt_haz || hilo_haz);
        issue    = id_valid && !stallreq && !stall_in;
    end

    assign hilo_busy = (hilo_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int r = 0; r < NREG; r++) begin
                pend_cnt[r] <= '0;
            end
            hilo_cnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (!stall_in && (pend_cnt[r] != '0)) begin
                    pend_cnt[r] <= pend_cnt[r] - PW'(1);
                end
            end
            // A newer writer supersedes any older load to the same register.
            if (issue && id_rf_we && (id_waddr != '0)) begin
                pend_cnt[id_waddr] <= id_is_load ? LOAD_SET : '0;
            end
            if (issue && id_is_md) begin
                hilo_cnt <= MD_SET;
            end else if (hilo_cnt != '0) begin
                hilo_cnt <= hilo_cnt - HW'(1);
            end
        end
    end

endmodule
